// File: rtl/greeble_pkg.sv
`default_nettype none
// ============================================================================
// Module   : greeble_pkg
// Brief    : Shared mode encodings, scan FSM states and default Galois taps.
// Revision : 1.0
// ============================================================================
package greeble_pkg;

    localparam logic [1:0] MODE_LEGACY = 2'b00;
    localparam logic [1:0] MODE_GALOIS = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_RELOAD = 2'b11;

    localparam logic [15:0] DEFAULT_GALOIS_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_RUN  = 2'd1,
        SCAN_DONE = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/greeble_core_v2.sv
`default_nettype none
// ============================================================================
// Module   : greeble_core_v2
// Brief    : One pseudo-random core: state/data registers and mode mux.
// Revision : 1.0
// ============================================================================
module greeble_core_v2
    import greeble_pkg::*;
#(
    parameter int                      DATA_W      = 8,
    parameter logic [2*DATA_W-1:0]     GALOIS_TAPS = (2*DATA_W)'(DEFAULT_GALOIS_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              reseed,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] data
);

    localparam int c_SW = 2 * DATA_W;

    logic [c_SW-1:0]   r_state;
    logic [DATA_W-1:0] r_data;

    // Reload shares the reset/reseed path; it only acts when the core is enabled.
    always_ff @(posedge clk) begin
        if (rst || reseed || (en && (mode == MODE_RELOAD))) begin
            r_state <= {seed, seed};
            r_data  <= '0;
        end else if (en) begin
            case (mode)
                MODE_LEGACY: begin
                    r_state <= {r_state[c_SW-2:0],
                                r_state[c_SW-1] ^ r_state[c_SW-3] ^ seed[0]};
                    r_data  <= r_state[c_SW-1:DATA_W] + r_state[DATA_W-1:0] + seed;
                end
                MODE_GALOIS: begin
                    r_state <= (r_state >> 1) ^ (r_state[0] ? GALOIS_TAPS : '0);
                    r_data  <= r_state[c_SW-1:DATA_W] ^ r_state[DATA_W-1:0];
                end
                default: begin
                    r_state <= r_state;
                    r_data  <= r_data;
                end
            endcase
        end
    end

    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/greeble_cluster_array.sv
`default_nettype none
// ============================================================================
// Module   : greeble_cluster_array
// Brief    : NUM_CORES greeble cores with XOR mix output and snapshot scan port.
// Revision : 1.0
// ============================================================================
module greeble_cluster_array
    import greeble_pkg::*;
#(
    parameter int                  NUM_CORES   = 16,
    parameter int                  DATA_W      = 8,
    parameter int                  SEED_OFFSET = 0,
    parameter logic [2*DATA_W-1:0] GALOIS_TAPS = (2*DATA_W)'(DEFAULT_GALOIS_TAPS),
    localparam int                 IDX_W       = $clog2(NUM_CORES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              reseed,
    input  logic [DATA_W-1:0] global_seed,
    output logic [DATA_W-1:0] mix_out,
    output logic              mix_valid,
    input  logic              scan_start,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic [DATA_W-1:0] scan_data,
    output logic [IDX_W-1:0]  scan_idx,
    output logic              scan_busy,
    output logic              scan_done
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CORES - 1);

    logic [DATA_W-1:0] w_seed   [NUM_CORES];
    logic [DATA_W-1:0] w_data   [NUM_CORES];
    logic [DATA_W-1:0] r_shadow [NUM_CORES];
    logic [DATA_W-1:0] w_mix;
    logic [DATA_W-1:0] r_mix;
    logic              r_mix_valid;
    logic [IDX_W-1:0]  r_idx;
    scan_state_t       r_scan_state;
    scan_state_t       w_scan_next;
    logic              w_scan_valid;
    logic              w_scan_busy;
    logic              w_scan_done;
    logic [DATA_W-1:0] w_scan_data;

    genvar i;
    generate
        for (i = 0; i < NUM_CORES; i++) begin : g_core
            assign w_seed[i] = global_seed + DATA_W'(SEED_OFFSET) + DATA_W'(i);

            greeble_core_v2 #(
                .DATA_W      (DATA_W),
                .GALOIS_TAPS (GALOIS_TAPS)
            ) u_core (
                .clk    (clk),
                .rst    (rst),
                .en     (en),
                .mode   (mode),
                .reseed (reseed),
                .seed   (w_seed[i]),
                .data   (w_data[i])
            );
        end
    endgenerate

    always_comb begin
        w_mix = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_mix = w_mix ^ w_data[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
        end else begin
            r_mix       <= w_mix;
            r_mix_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_state <= SCAN_IDLE;
        end else begin
            r_scan_state <= w_scan_next;
        end
    end

    always_comb begin
        w_scan_next  = r_scan_state;
        w_scan_valid = 1'b0;
        w_scan_busy  = 1'b0;
        w_scan_done  = 1'b0;
        w_scan_data  = '0;
        case (r_scan_state)
            SCAN_IDLE: begin
                if (scan_start) begin
                    w_scan_next = SCAN_RUN;
                end
            end
            SCAN_RUN: begin
                w_scan_valid = 1'b1;
                w_scan_busy  = 1'b1;
                w_scan_data  = r_shadow[r_idx];
                if (scan_ready && (r_idx == c_LAST_IDX)) begin
                    w_scan_next = SCAN_DONE;
                end
            end
            SCAN_DONE: begin
                w_scan_busy = 1'b1;
                w_scan_done = 1'b1;
                w_scan_next = SCAN_IDLE;
            end
            default: begin
                w_scan_next = SCAN_IDLE;
            end
        endcase
    end

    // The shadow is written only on the IDLE->SCAN edge, so core activity never disturbs a stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                r_shadow[k] <= '0;
            end
        end else if ((r_scan_state == SCAN_IDLE) && scan_start) begin
            r_idx <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                r_shadow[k] <= w_data[k];
            end
        end else if ((r_scan_state == SCAN_RUN) && scan_ready && (r_idx != c_LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign mix_out    = r_mix;
    assign mix_valid  = r_mix_valid;
    assign scan_valid = w_scan_valid;
    assign scan_busy  = w_scan_busy;
    assign scan_done  = w_scan_done;
    assign scan_data  = w_scan_data;
    assign scan_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_greeble_cluster_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_greeble_cluster_array
// Brief    : Directed self-checking bench for a 4-core, 8-bit cluster.
// Revision : 1.0
// ============================================================================
module tb_greeble_cluster_array;

    localparam int NUM_CORES = 4;
    localparam int DATA_W    = 8;

    logic              clk;
    logic              rst;
    logic              en;
    logic [1:0]        mode;
    logic              reseed;
    logic [DATA_W-1:0] global_seed;
    logic [DATA_W-1:0] mix_out;
    logic              mix_valid;
    logic              scan_start;
    logic              scan_valid;
    logic              scan_ready;
    logic [DATA_W-1:0] scan_data;
    logic [1:0]        scan_idx;
    logic              scan_busy;
    logic              scan_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];

    greeble_cluster_array #(
        .NUM_CORES   (NUM_CORES),
        .DATA_W      (DATA_W),
        .SEED_OFFSET (0),
        .GALOIS_TAPS (16'hB400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .reseed      (reseed),
        .global_seed (global_seed),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .scan_start  (scan_start),
        .scan_valid  (scan_valid),
        .scan_ready  (scan_ready),
        .scan_data   (scan_data),
        .scan_idx    (scan_idx),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_a = '{8'h30, 8'h33, 8'h36, 8'h39};
        exp_b = '{8'h50, 8'h56, 8'h5A, 8'h60};
        rst = 1'b1; en = 1'b0; mode = 2'b00; reseed = 1'b0;
        global_seed = 8'h10; scan_start = 1'b0; scan_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_mix_out",   32'(mix_out), 32'h00);
        check("rst_mix_valid", 32'(mix_valid), 32'h0);
        check("rst_scan_valid", 32'(scan_valid), 32'h0);
        check("rst_scan_busy", 32'(scan_busy), 32'h0);
        check("rst_scan_done", 32'(scan_done), 32'h0);
        check("rst_scan_idx",  32'(scan_idx), 32'h0);
        check("rst_scan_data", 32'(scan_data), 32'h0);
        check("rst_core2_state", 32'(dut.g_core[2].u_core.r_state), 32'h1212);
        check("rst_core3_state", 32'(dut.g_core[3].u_core.r_state), 32'h1313);
        rst = 1'b0;
        tick();
        check("mix_valid_after_rst", 32'(mix_valid), 32'h1);
        check("mix_zero_after_rst", 32'(mix_out), 32'h00);

        // One LEGACY step, then hold via en=0
        en = 1'b1; mode = 2'b00;
        tick();
        en = 1'b0;
        tick();
        check("legacy_mix", 32'(mix_out), 32'h0C);
        check("legacy_core2_state", 32'(dut.g_core[2].u_core.r_state), 32'h2424);

        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        scan_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            check("legacy_scan_valid", 32'(scan_valid), 32'h1);
            check("legacy_scan_idx", 32'(scan_idx), 32'(b));
            check("legacy_scan_data", 32'(scan_data), 32'(exp_a[b]));
            tick();
        end
        scan_ready = 1'b0;
        check("legacy_scan_done", 32'(scan_done), 32'h1);
        tick();
        check("legacy_scan_idle", 32'(scan_busy), 32'h0);

        // Frozen under en=0 and under HOLD
        for (int c = 0; c < 10; c++) tick();
        check("en0_mix_frozen", 32'(mix_out), 32'h0C);
        en = 1'b1; mode = 2'b10;
        for (int c = 0; c < 10; c++) tick();
        check("hold_mix_frozen", 32'(mix_out), 32'h0C);
        check("hold_core2_state", 32'(dut.g_core[2].u_core.r_state), 32'h2424);

        // Second LEGACY step
        mode = 2'b00;
        tick();
        en = 1'b0;
        tick();
        check("legacy2_mix", 32'(mix_out), 32'h3C);

        // Scan with stalls and an ignored mid-scan start
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("stall_scan_valid", 32'(scan_valid), 32'h1);
            check("stall_scan_idx", 32'(scan_idx), 32'(b));
            check("stall_scan_data", 32'(scan_data), 32'(exp_b[b]));
            if (b == 1) scan_start = 1'b1;
            tick();
            scan_start = 1'b0;
            check("stalled_idx", 32'(scan_idx), 32'(b));
            check("stalled_data", 32'(scan_data), 32'(exp_b[b]));
            check("stalled_done", 32'(scan_done), 32'h0);
            scan_ready = 1'b1;
            tick();
            scan_ready = 1'b0;
        end
        check("stall_done_pulse", 32'(scan_done), 32'h1);
        check("stall_done_valid", 32'(scan_valid), 32'h0);
        check("stall_done_busy", 32'(scan_busy), 32'h1);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("done_one_cycle", 32'(scan_done), 32'h0);
        check("start_in_done_ignored", 32'(scan_busy), 32'h0);
        tick();
        check("still_idle", 32'(scan_valid), 32'h0);

        // Reseed on the same edge as scan_start
        reseed = 1'b1; scan_start = 1'b1;
        tick();
        reseed = 1'b0; scan_start = 1'b0; scan_ready = 1'b1;
        check("reseed_core3_state", 32'(dut.g_core[3].u_core.r_state), 32'h1313);
        check("reseed_core0_data", 32'(dut.g_core[0].u_core.r_data), 32'h00);
        check("reseed_mix_pre", 32'(mix_out), 32'h3C);
        for (int b = 0; b < 4; b++) begin
            check("reseed_scan_idx", 32'(scan_idx), 32'(b));
            check("reseed_scan_data", 32'(scan_data), 32'(exp_b[b]));
            tick();
            if (b == 0) check("reseed_mix_post", 32'(mix_out), 32'h00);
        end
        scan_ready = 1'b0;
        check("reseed_scan_done", 32'(scan_done), 32'h1);
        tick();

        // GALOIS from 16'h1010 on core 0, then RELOAD
        en = 1'b1; mode = 2'b01;
        for (int c = 0; c < 4; c++) tick();
        check("galois_4", 32'(dut.g_core[0].u_core.r_state), 32'h0101);
        tick();
        check("galois_taps", 32'(dut.g_core[0].u_core.r_state), 32'hB480);
        tick();
        check("galois_6", 32'(dut.g_core[0].u_core.r_state), 32'h5A40);
        check("galois_data", 32'(dut.g_core[0].u_core.r_data), 32'h34);
        mode = 2'b11;
        tick();
        check("reload_core0_state", 32'(dut.g_core[0].u_core.r_state), 32'h1010);
        check("reload_core0_data", 32'(dut.g_core[0].u_core.r_data), 32'h00);
        check("reload_core3_state", 32'(dut.g_core[3].u_core.r_state), 32'h1313);
        en = 1'b0; mode = 2'b00;

        // Reset during an idx 2 stall
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0; scan_ready = 1'b1;
        tick();
        tick();
        scan_ready = 1'b0;
        check("pre_rst_idx", 32'(scan_idx), 32'h2);
        check("pre_rst_valid", 32'(scan_valid), 32'h1);
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(scan_valid), 32'h0);
        check("midrst_busy", 32'(scan_busy), 32'h0);
        check("midrst_done", 32'(scan_done), 32'h0);
        check("midrst_mix_valid", 32'(mix_valid), 32'h0);
        rst = 1'b0;
        tick();
        check("postrst_done", 32'(scan_done), 32'h0);
        check("postrst_busy", 32'(scan_busy), 32'h0);
        check("postrst_mix_valid", 32'(mix_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
